// File: rtl/serial_paralelo_azul.sv
// Blue-lane serial-to-parallel receiver: MSB-first deserializer that aligns on the COM
// idle symbol, declares lock after BC_COUNT aligned COMs and presents recovered bytes.
module serial_paralelo_azul #(
    parameter logic [7:0]  COM      = 8'hBC,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk32_f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_tick,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam logic [3:0] BC_LIM = 4'(BC_COUNT);

    state_t     state_q, state_d;
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       tick_q, tick_d;

    // Only the seven newest bits are stored; the eighth is data_in itself.
    logic [7:0] w;
    logic       w_is_com;
    logic       boundary;
    logic [3:0] bc_inc;

    assign w        = {shift_reg, data_in};
    assign w_is_com = (w == COM);
    assign boundary = (bit_cnt_q == 3'd7);
    assign bc_inc   = bc_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;
        tick_d    = 1'b0;
        case (state_q)
            HUNT: begin
                if (w_is_com) begin
                    bc_cnt_d  = 4'd1;
                    bit_cnt_d = 3'd0;
                    if (BC_LIM <= 4'd1) begin
                        state_d  = LOCK;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                tick_d    = boundary;
                valid_d   = 1'b0;
                if (boundary) begin
                    if (w_is_com) begin
                        if (bc_inc >= BC_LIM) begin
                            bc_cnt_d = BC_LIM;
                            state_d  = LOCK;
                            active_d = 1'b1;
                        end else begin
                            bc_cnt_d = bc_inc;
                        end
                    end else begin
                        // Rejected frame: bitwise search restarts on the next edge.
                        bc_cnt_d = 4'd0;
                        state_d  = HUNT;
                    end
                end
            end
            LOCK: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                tick_d    = boundary;
                if (boundary) begin
                    if (w_is_com) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = w;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk32_f or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            shift_reg <= 7'd0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_reg <= w[6:0];
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            tick_q    <= tick_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;
    assign byte_tick = tick_q;
    assign state_dbg = state_q;

endmodule
